matrix3_scan_controller: RTL

MATRIX3_SCAN_CONTROLLER -- requirements
Module: matrix3_scan_controller

---
 rtl/matrix3_scan_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/matrix3_scan_controller.sv
// Raster-order scan controller for a rolling P_ROWS-line buffer: writes incoming
// pixels, then issues one 3x3 window read per column once three rows are present.
module matrix3_scan_controller #(
    parameter int  P_COLUMNS     = 640,
    parameter int  P_ROWS        = 4,
    parameter int  P_FRAME_ROWS  = 480,
    parameter int  P_PIXEL_DEPTH = 4,
    localparam int CB            = $clog2(P_COLUMNS),
    localparam int RB            = $clog2(P_ROWS),
    localparam int FB            = $clog2(P_FRAME_ROWS)
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_PIXEL_VALID,
    input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
    output logic                     O_READY,
    input  logic                     I_SINK_READY,
    output logic [CB-1:0]            O_BUF_COLUMN,
    output logic [RB-1:0]            O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0] O_BUF_PIXEL,
    output logic                     O_BUF_WRITE_ENABLE,
    output logic                     O_BUF_READ_ENABLE,
    output logic                     O_MATRIX_VALID,
    output logic [CB-1:0]            O_MATRIX_COLUMN,
    output logic [FB-1:0]            O_MATRIX_ROW,
    output logic                     O_MATRIX_BORDER,
    output logic                     O_FRAME_DONE
);

    localparam logic [CB-1:0] COL_LAST  = CB'(P_COLUMNS - 1);
    localparam logic [CB-1:0] COL_ONE   = CB'(1);
    localparam logic [RB-1:0] ROW_LAST  = RB'(P_ROWS - 1);
    localparam logic [RB-1:0] ROW_ONE   = RB'(1);
    localparam logic [FB-1:0] WROW_LAST = FB'(P_FRAME_ROWS - 1);
    localparam logic [FB-1:0] WROW_ONE  = FB'(1);
    localparam logic [FB-1:0] WROW_TWO  = FB'(2);

    typedef enum logic [1:0] {
        S_WRITE = 2'd0,
        S_READ  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CB-1:0]            col_q, col_d;
    logic [FB-1:0]            wrow_q, wrow_d;
    // Buffer rows of the written frame row and of the centre row, kept alongside wrow
    logic [RB-1:0]            wbuf_q, wbuf_d;
    logic [RB-1:0]            rbuf_q, rbuf_d;

    logic                     mat_valid_q;
    logic [CB-1:0]            mat_col_q;
    logic [FB-1:0]            mat_row_q;
    logic                     mat_border_q;

    logic                     ready_c;
    logic                     buf_write_c;
    logic                     buf_read_c;
    logic [RB-1:0]            buf_row_c;
    logic [CB-1:0]            buf_col_c;
    logic [P_PIXEL_DEPTH-1:0] buf_pixel_c;
    logic                     frame_done_c;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        wrow_d       = wrow_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        ready_c      = 1'b0;
        buf_write_c  = 1'b0;
        buf_read_c   = 1'b0;
        buf_row_c    = '0;
        buf_col_c    = '0;
        buf_pixel_c  = '0;
        frame_done_c = 1'b0;

        if (!I_RESET) begin
            case (state_q)
                S_WRITE: begin
                    ready_c     = 1'b1;
                    buf_write_c = I_PIXEL_VALID;
                    buf_row_c   = wbuf_q;
                    buf_col_c   = col_q;
                    buf_pixel_c = I_PIXEL;
                    if (I_PIXEL_VALID) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            // The first three rows are written back to back before any read
                            if (wrow_q < WROW_TWO) begin
                                wrow_d = wrow_q + WROW_ONE;
                                wbuf_d = (wbuf_q == ROW_LAST) ? '0 : wbuf_q + ROW_ONE;
                                rbuf_d = wbuf_q;
                            end else begin
                                state_d = S_READ;
                            end
                        end else begin
                            col_d = col_q + COL_ONE;
                        end
                    end
                end

                S_READ: begin
                    buf_read_c = I_SINK_READY;
                    buf_row_c  = rbuf_q;
                    buf_col_c  = col_q;
                    if (I_SINK_READY) begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (wrow_q == WROW_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                wrow_d  = wrow_q + WROW_ONE;
                                wbuf_d  = (wbuf_q == ROW_LAST) ? '0 : wbuf_q + ROW_ONE;
                                rbuf_d  = wbuf_q;
                                state_d = S_WRITE;
                            end
                        end else begin
                            col_d = col_q + COL_ONE;
                        end
                    end
                end

                S_DONE: begin
                    frame_done_c = 1'b1;
                    col_d        = '0;
                    wrow_d       = '0;
                    wbuf_d       = '0;
                    rbuf_d       = ROW_LAST;
                    state_d      = S_WRITE;
                end

                default: begin
                    state_d = S_WRITE;
                end
            endcase
        end
    end

    // Matrix outputs follow the read strobe by one cycle, matching the buffer's registered read port
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q      <= S_WRITE;
            col_q        <= '0;
            wrow_q       <= '0;
            wbuf_q       <= '0;
            rbuf_q       <= ROW_LAST;
            mat_valid_q  <= 1'b0;
            mat_col_q    <= '0;
            mat_row_q    <= '0;
            mat_border_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            wrow_q      <= wrow_d;
            wbuf_q      <= wbuf_d;
            rbuf_q      <= rbuf_d;
            mat_valid_q <= buf_read_c;
            if (buf_read_c) begin
                mat_col_q    <= col_q;
                mat_row_q    <= wrow_q - WROW_ONE;
                mat_border_q <= (col_q == '0) || (col_q == COL_LAST);
            end
        end
    end

    assign O_READY            = ready_c;
    assign O_BUF_WRITE_ENABLE = buf_write_c;
    assign O_BUF_READ_ENABLE  = buf_read_c;
    assign O_BUF_ROW          = buf_row_c;
    assign O_BUF_COLUMN       = buf_col_c;
    assign O_BUF_PIXEL        = buf_pixel_c;
    assign O_FRAME_DONE       = frame_done_c;

    // Registered outputs are forced low while reset is held so every output reads zero
    assign O_MATRIX_VALID  = mat_valid_q & ~I_RESET;
    assign O_MATRIX_COLUMN = I_RESET ? '0 : mat_col_q;
    assign O_MATRIX_ROW    = I_RESET ? '0 : mat_row_q;
    assign O_MATRIX_BORDER = mat_border_q & ~I_RESET;

endmodule
